// File: rtl/vm_change_dispenser.sv
// Change-return engine: pays (credit - price) coins out to the hopper as
// PULSE_LEN-wide coin_out pulses, each confirmed by coin_ack or timed out.
module vm_change_dispenser #(
  parameter int unsigned PULSE_LEN   = 2,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] credit,
  input  logic [2:0] price,
  input  logic       coin_ack,
  output logic       coin_out,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] change_left
);

  localparam int unsigned CW = 3;
  localparam int unsigned PW = $clog2(PULSE_LEN + 1);
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PULSE = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [CW-1:0] cl_q, cl_d;
  logic          err_q, err_d;
  logic          coin_out_q, coin_out_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pcnt_q     <= '0;
      tcnt_q     <= '0;
      cl_q       <= '0;
      err_q      <= 1'b0;
      coin_out_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      tcnt_q     <= tcnt_d;
      cl_q       <= cl_d;
      err_q      <= err_d;
      coin_out_q <= coin_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and datapath; an ack on the final timeout cycle beats the timeout.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    tcnt_d  = tcnt_q;
    cl_d    = cl_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d  = 1'b0;
          pcnt_d = '0;
          if (credit < price) begin
            err_d   = 1'b1;
            cl_d    = '0;
            state_d = S_DONE;
          end else begin
            cl_d    = CW'(credit - price);
            state_d = (credit == price) ? S_DONE : S_PULSE;
          end
        end
      end
      S_PULSE: begin
        if (pcnt_q == PW'(PULSE_LEN - 1)) begin
          pcnt_d  = '0;
          tcnt_d  = '0;
          state_d = S_WAIT;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
      S_WAIT: begin
        if (coin_ack) begin
          cl_d    = cl_q - CW'(1);
          state_d = (cl_q == CW'(1)) ? S_DONE : S_GAP;
        end else if (tcnt_q == TW'(ACK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_GAP: begin
        pcnt_d  = '0;
        state_d = S_PULSE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_comb begin
    coin_out_d = (state_d == S_PULSE);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  assign coin_out    = coin_out_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign change_left = cl_q;

endmodule

// File: doc/vm_change_dispenser.md
# vm_change_dispenser

Change-return engine for the vending machine: it is the payout end of the coin interface. The credit FSM counts coins in. This block takes the final credit and the product price, and pays the difference back out as individual coin pulses to an external hopper. Each pulse is confirmed by a hopper acknowledge, and a missing acknowledge is caught by a timeout. It runs on the same prescaled internal clock as the credit and dispense FSMs and is started once per completed sale.

## Interface
- PULSE_LEN, default 2: cycles `coin_out` stays high per coin (≥1).
- ACK_TIMEOUT, default 8: cycles to wait for `coin_ack` after a pulse before flagging an error (≥1).
- clk  input  1  internal (prescaled) clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to pay change; honoured only in IDLE.
- credit  input  3  credit value, in coins, sampled on the `start` cycle.
- price  input  3  product price, in coins, sampled on the `start` cycle.
- coin_ack  input  1  hopper confirms that one coin was ejected; sampled only in WAIT_ACK.
- coin_out  output  1  eject-one-coin command to the hopper.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  sticky error flag; cleared by reset or by the next accepted `start`.
- change_left  output  3  coins still owed.

## Operation
- All outputs are registered or decoded from state. Reset values: `coin_out`=0, `busy`=0, `done`=0, `err`=0, `change_left`=0, state IDLE, both counters 0.
- States: IDLE, PULSE, WAIT_ACK, GAP, DONE.
- **IDLE**, when `start`=1:
  - Clear `err`.
  - If `credit` < `price`: set `err`=1, `change_left`=0, go to DONE. No coins are paid.
  - Else set `change_left` = `credit` − `price` (3-bit unsigned, no wrap possible).
  - If the result is 0, go to DONE. Otherwise go to PULSE.
- **PULSE**:
  - `coin_out`=1 for exactly PULSE_LEN cycles, counted by the pulse counter.
  - Then go to WAIT_ACK with the timeout counter at 0.
- **WAIT_ACK**, `coin_out`=0:
  - On `coin_ack`=1, decrement `change_left`. If the new value is 0, go to DONE; otherwise go to GAP.
  - If ACK_TIMEOUT cycles elapse with no ack, set `err`=1, leave `change_left` unchanged (it holds the unpaid amount), and go to DONE.
- **GAP**: one cycle with `coin_out`=0, then go to PULSE. This guarantees a low gap between coins.
- **DONE**: `done`=1 for one cycle, then go to IDLE.
- `start` is ignored in every state other than IDLE.
- `coin_ack` is ignored outside WAIT_ACK. An ack asserted during PULSE does not count.
- If an ack arrives on the same cycle the timeout expires, the ack wins: the coin counts and no error is raised.
- `reset` mid-payout:
  - Takes effect at the next edge.
  - Aborts any pulse.
  - Returns all outputs to their reset values, without a `done` pulse.
- `err` and `change_left` persist through IDLE until the next accepted `start` or `reset`.

## Timing
- `start` sampled at edge E0:
  - `busy`=1 and `coin_out`=1 from E0.
  - `coin_out` falls at edge E0+PULSE_LEN.
- `coin_ack` sampled at edge Ea in WAIT_ACK:
  - `change_left` updates at Ea.
  - Next `coin_out` rises at Ea+1 (after the GAP cycle), or `done` is high for cycle Ea..Ea+1 if this was the last coin.
- Timeout: WAIT_ACK entered at edge Ew with no ack → `err`=1 and `done`=1 from edge Ew+ACK_TIMEOUT. `busy` drops one cycle later.
- Zero-change or insufficient-credit request: `done` pulses in the cycle after `start`; `busy` is high for that one cycle only.
- Minimum per-coin period: PULSE_LEN + 1 (ack cycle) + 1 (gap).

## Test plan
Parameters for all scenarios: PULSE_LEN=2, ACK_TIMEOUT=8.
- **Normal payout.** `credit`=5, `price`=3, hopper acks 1 cycle after each pulse. Required: exactly 2 `coin_out` pulses, each 2 cycles wide, separated by a low gap; `change_left` steps 2→1→0; single `done` pulse; `err`=0.
- **Exact and insufficient credit.**
  - `credit`=3, `price`=3: `done` the next cycle, no pulses, `err`=0.
  - `credit`=2, `price`=4: `done` the next cycle, no pulses, `err`=1, `change_left`=0.
- **Hopper stall.** `credit`=6, `price`=2, first coin acked, then no more acks. Required: `err`=1 and `done` exactly 8 cycles after the second pulse falls; `change_left`=3; `err` still high in IDLE until the next `start` clears it.
- **Ack edge cases.**
  - `coin_ack` held high during PULSE: no decrement until WAIT_ACK.
  - Ack on the final timeout cycle: counted, `err`=0.
- **Start while busy.** A second `start` with `credit`=7, `price`=0 during a payout is ignored; the total number of pulses equals the first request only.
- **Reset mid-operation.** `reset` asserted during the second pulse of a 4-coin payout. Required: at the next edge `coin_out`=0, `busy`=0, `change_left`=0, state IDLE, no `done` pulse; a fresh `start` then behaves normally.
